// File: rtl/buzzer_tone_master_pkg.sv
// Shared types and constants for the buzzer tone initiator.
package buzzer_tone_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    RWAIT,
    HOLD,
    OFF,
    OFFRD,
    OFFRW
  } state_t;

  // Word address of the PIO data register on the buzzer slave.
  localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

  localparam int HP_W_DEF   = 16;
  localparam int CNT_W_DEF  = 16;
  localparam int AVM_ADDR_W = 2;
  localparam int AVM_DATA_W = 32;

endpackage

// File: rtl/buzzer_tone_master_if.sv
// Avalon-MM link between the tone initiator and the buzzer PIO slave.
interface buzzer_tone_master_if;
  import buzzer_tone_master_pkg::*;

  logic [AVM_ADDR_W-1:0] avm_address;
  logic                  avm_write;
  logic                  avm_read;
  logic [AVM_DATA_W-1:0] avm_writedata;
  logic                  avm_waitrequest;
  logic [AVM_DATA_W-1:0] avm_readdata;
  logic                  avm_readdatavalid;

  modport master (
    output avm_address, avm_write, avm_read, avm_writedata,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid
  );

  modport slave (
    input  avm_address, avm_write, avm_read, avm_writedata,
    output avm_waitrequest, avm_readdata, avm_readdatavalid
  );

endinterface

// File: rtl/buzzer_tone_master_tone_phase_counter.sv
// Loadable down-counter timing one high or low phase of the tone.
module buzzer_tone_master_tone_phase_counter
  import buzzer_tone_master_pkg::*;
#(
  parameter int HP_W = HP_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [HP_W-1:0] load_val,
  input  logic            en,
  output logic            zero
);

  logic [HP_W-1:0] count;

  // Load has priority; decrement stops at zero so the flag stays put.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - HP_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/buzzer_tone_master.sv
// Avalon-MM initiator toggling the buzzer PIO data register to make a
// square-wave tone, reading each written level back to catch bus faults.
module buzzer_tone_master
  import buzzer_tone_master_pkg::*;
#(
  parameter int                    HP_W     = HP_W_DEF,
  parameter int                    CNT_W    = CNT_W_DEF,
  parameter logic [AVM_ADDR_W-1:0] PIO_ADDR = PIO_DATA_ADDR
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [HP_W-1:0]       half_period,
  input  logic [CNT_W-1:0]      periods,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  buzzer_tone_master_if.master  avm
);

  state_t          state;
  logic            level;
  logic [HP_W-1:0] hp;
  logic [CNT_W-1:0] rem;
  logic            err_q;
  logic            done_q;
  logic            wr_q;
  logic            rd_q;
  logic            abort_pend;

  logic            abort_any;
  logic            rd_bad;
  logic [CNT_W-1:0] rem_dec;
  logic            cnt_load;
  logic            cnt_en;
  logic            cnt_zero;
  logic            unused_readdata;

  // A zero half-period would make HOLD degenerate; clamp it to one cycle.
  function automatic logic [HP_W-1:0] sat_hp(input logic [HP_W-1:0] v);
    return (v == '0) ? HP_W'(1) : v;
  endfunction

  assign abort_any       = abort | abort_pend;
  assign rd_bad          = (avm.avm_readdata[0] != level);
  assign rem_dec         = rem - CNT_W'(1);
  assign unused_readdata = ^avm.avm_readdata[AVM_DATA_W-1:1];

  // Phase timer is loaded with hp-1 when the readback lands, giving hp HOLD cycles.
  assign cnt_load = (state == RWAIT) && avm.avm_readdatavalid;
  assign cnt_en   = (state == HOLD) && !cnt_zero;

  buzzer_tone_master_tone_phase_counter #(
    .HP_W (HP_W)
  ) u_phase_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (hp - HP_W'(1)),
    .en       (cnt_en),
    .zero     (cnt_zero)
  );

  // Tone sequencer: write level, read it back, hold, toggle; abort drains the
  // in-flight transfer before driving the buzzer off.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      level      <= 1'b0;
      hp         <= '0;
      rem        <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      abort_pend <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          abort_pend <= 1'b0;
          if (start) begin
            err_q <= 1'b0;
            hp    <= sat_hp(half_period);
            rem   <= periods;
            level <= 1'b1;
            if (periods == '0) begin
              done_q <= 1'b1;
            end else begin
              state <= WRITE;
              wr_q  <= 1'b1;
            end
          end
        end

        WRITE: begin
          if (abort) abort_pend <= 1'b1;
          if (!avm.avm_waitrequest) begin
            if (abort_any) begin
              state <= OFF;
              level <= 1'b0;
            end else begin
              state <= READ;
              wr_q  <= 1'b0;
              rd_q  <= 1'b1;
            end
          end
        end

        READ: begin
          if (abort) abort_pend <= 1'b1;
          if (!avm.avm_waitrequest) begin
            state <= RWAIT;
            rd_q  <= 1'b0;
          end
        end

        RWAIT: begin
          if (abort) abort_pend <= 1'b1;
          if (avm.avm_readdatavalid) begin
            if (rd_bad) err_q <= 1'b1;
            if (abort_any) begin
              state <= OFF;
              level <= 1'b0;
              wr_q  <= 1'b1;
            end else begin
              state <= HOLD;
            end
          end
        end

        HOLD: begin
          if (abort) begin
            state <= OFF;
            level <= 1'b0;
            wr_q  <= 1'b1;
          end else if (cnt_zero) begin
            if (level) begin
              level <= 1'b0;
              state <= WRITE;
              wr_q  <= 1'b1;
            end else begin
              rem <= rem_dec;
              if (rem_dec == '0) begin
                state  <= IDLE;
                done_q <= 1'b1;
              end else begin
                level <= 1'b1;
                state <= WRITE;
                wr_q  <= 1'b1;
              end
            end
          end
        end

        OFF: begin
          if (!avm.avm_waitrequest) begin
            state <= OFFRD;
            wr_q  <= 1'b0;
            rd_q  <= 1'b1;
          end
        end

        OFFRD: begin
          if (!avm.avm_waitrequest) begin
            state <= OFFRW;
            rd_q  <= 1'b0;
          end
        end

        OFFRW: begin
          if (avm.avm_readdatavalid) begin
            if (rd_bad) err_q <= 1'b1;
            state  <= IDLE;
            done_q <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign busy              = (state != IDLE);
  assign done              = done_q;
  assign err               = err_q;
  assign avm.avm_address   = PIO_ADDR;
  assign avm.avm_write     = wr_q;
  assign avm.avm_read      = rd_q;
  assign avm.avm_writedata = {{(AVM_DATA_W-1){1'b0}}, level};

endmodule

// File: tb/tb_buzzer_tone_master.sv
// Scoreboard bench for buzzer_tone_master with a mirroring PIO slave model.
module tb_buzzer_tone_master;
  import buzzer_tone_master_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [15:0] half_period;
  logic [15:0] periods;
  logic        busy;
  logic        done;
  logic        err;

  buzzer_tone_master_if bus ();

  buzzer_tone_master dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .half_period (half_period),
    .periods     (periods),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .avm         (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  bit exp_wr[$];
  int reads_cnt   = 0;
  int rdv_cnt     = 0;
  int stall_obs   = 0;
  int stall_budget = 0;
  int stall_used  = 0;
  bit force_zero  = 1'b0;
  bit hold_chk_en = 1'b1;
  int exp_gap     = 0;
  logic pio_reg;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Slave: stalls writes while budget remains, mirrors data register, read latency 1.
  assign bus.avm_waitrequest = bus.avm_write && (stall_used < stall_budget);

  always @(posedge clk) begin
    if (reset) begin
      pio_reg               <= 1'b0;
      bus.avm_readdatavalid <= 1'b0;
      bus.avm_readdata      <= '0;
    end else begin
      if (bus.avm_write && !bus.avm_waitrequest) pio_reg <= bus.avm_writedata[0];
      if (bus.avm_write && bus.avm_waitrequest) stall_used <= stall_used + 1;
      bus.avm_readdatavalid <= bus.avm_read && !bus.avm_waitrequest;
      bus.avm_readdata      <= force_zero ? 32'd0 : {31'b0, pio_reg};
    end
  end

  // Bus monitor: pops scoreboard on accepted writes, checks hold stability and phase length.
  initial begin
    bit          stall_prev = 1'b0;
    logic [31:0] stall_wd   = '0;
    bit          gap_arm    = 1'b0;
    int          gap_cnt    = 0;
    bit          lvl;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.avm_write || bus.avm_read)
          chk("wr_rd_excl", int'(bus.avm_write && bus.avm_read), 0);
        if (bus.avm_write && stall_prev)
          chk("wr_hold_data", int'(bus.avm_writedata), int'(stall_wd));
        stall_prev = bus.avm_write && bus.avm_waitrequest;
        if (stall_prev) begin
          stall_wd = bus.avm_writedata;
          stall_obs++;
        end
        if (bus.avm_write && !bus.avm_waitrequest) begin
          chk("wr_addr", int'(bus.avm_address), 0);
          chk("wr_pending", int'(exp_wr.size() != 0), 1);
          if (exp_wr.size() != 0) begin
            lvl = exp_wr.pop_front();
            chk("wr_data", int'(bus.avm_writedata), int'(lvl));
          end
        end
        if (bus.avm_read && !bus.avm_waitrequest) reads_cnt++;
        if (bus.avm_readdatavalid) begin
          rdv_cnt++;
          gap_arm = 1'b1;
          gap_cnt = 0;
        end else if (gap_arm) begin
          gap_cnt++;
          if (bus.avm_write || done) begin
            if (hold_chk_en) chk("hold_len", gap_cnt, exp_gap);
            gap_arm = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic start_tone(input int hp, input int per);
    @(negedge clk);
    half_period = 16'(hp);
    periods     = 16'(per);
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_on", int'(busy), int'(per != 0));
    chk("err_clr", int'(err), 0);
  endtask

  task automatic wait_done(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    chk("done_seen", int'(ok), 1);
  endtask

  task automatic finish_checks(input int exp_reads, input int exp_err);
    chk("busy_off", int'(busy), 0);
    chk("err_end", int'(err), exp_err);
    chk("wr_all_seen", exp_wr.size(), 0);
    chk("reads", reads_cnt, exp_reads);
    @(negedge clk);
    chk("done_width", int'(done), 0);
  endtask

  task automatic run_tone(input int hp, input int per, input int exp_err);
    reads_cnt = 0;
    exp_gap   = ((hp == 0) ? 1 : hp) + 1;
    for (int p = 0; p < per; p++) begin
      exp_wr.push_back(1'b1);
      exp_wr.push_back(1'b0);
    end
    start_tone(hp, per);
    wait_done(2000);
    finish_checks(2 * per, exp_err);
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    abort       = 1'b0;
    half_period = '0;
    periods     = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_write", int'(bus.avm_write), 0);
    chk("rst_read", int'(bus.avm_read), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Basic tone, no stalls.
    run_tone(3, 2, 0);

    // Zero periods: immediate done, no traffic.
    start_tone(4, 0);
    chk("p0_done", int'(done), 1);
    chk("p0_write", int'(bus.avm_write), 0);
    chk("p0_read", int'(bus.avm_read), 0);
    @(negedge clk);
    chk("p0_done_width", int'(done), 0);
    chk("p0_busy", int'(busy), 0);
    chk("p0_write2", int'(bus.avm_write), 0);

    // First write stalled for four cycles.
    stall_obs    = 0;
    stall_budget = stall_used + 4;
    run_tone(2, 1, 0);
    chk("stall_cycles", stall_obs, 4);

    // Abort during the first high phase.
    hold_chk_en = 1'b0;
    reads_cnt   = 0;
    rdv_cnt     = 0;
    exp_wr.push_back(1'b1);
    exp_wr.push_back(1'b0);
    start_tone(10, 5);
    for (int i = 0; i < 100 && rdv_cnt < 1; i++) @(negedge clk);
    chk("abort_rdv", rdv_cnt, 1);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done(200);
    chk("abort_buzzer_off", int'(pio_reg), 0);
    finish_checks(2, 0);
    hold_chk_en = 1'b1;

    // Corrupted readback of the high level, then a clean tone clears err.
    force_zero = 1'b1;
    run_tone(2, 2, 1);
    force_zero = 1'b0;
    chk("err_sticky", int'(err), 1);
    run_tone(1, 1, 0);

    // hp=0 behaves as hp=1; a second start while busy is ignored.
    reads_cnt = 0;
    exp_gap   = 2;
    exp_wr.push_back(1'b1);
    exp_wr.push_back(1'b0);
    start_tone(0, 1);
    half_period = 16'd5;
    periods     = 16'd3;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(200);
    finish_checks(2, 0);
    begin
      int extra = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (done || busy) extra++;
      end
      chk("ignored_start", extra, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
